// File: rtl/regs_sb.sv
// regs_sb: parametrised GPR file with W (execute) and L (load return) write
// ports, combinational bypassed reads, a per-register outstanding-load
// scoreboard and a sequential zero-fill sweep instead of storage reset.
//
// Optional feature macro: REGS_SB_SCOREBOARD_EN
//   defined   : busy bits, iss_ld/iss_rd, flush and hz_a/hz_b are active
//   undefined : no busy bits, hz_a/hz_b tied to 0, iss_ld/iss_rd/flush ignored
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   ra_a/ra_b -> rd_a/rd_b      read ports (combinational, bypassed)
//   hz_a/hz_b                   read register has an outstanding load
//   w_we/w_addr/w_data          W write port (wins over L on same address)
//   l_we/l_addr/l_data          L write port, also clears busy
//   iss_ld/iss_rd               load issue, sets busy
//   flush                       clear all busy bits
//   clr_req                     start a full storage clear sweep
//   ready                       storage valid (0 while sweeping)
//   dbg_addr -> dbg_data        raw storage read, no bypass
module regs_sb #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   ra_a,
   input  logic [AW-1:0]   ra_b,
   output logic [XLEN-1:0] rd_a,
   output logic [XLEN-1:0] rd_b,
   output logic            hz_a,
   output logic            hz_b,
   input  logic            w_we,
   input  logic [AW-1:0]   w_addr,
   input  logic [XLEN-1:0] w_data,
   input  logic            l_we,
   input  logic [AW-1:0]   l_addr,
   input  logic [XLEN-1:0] l_data,
   input  logic            iss_ld,
   input  logic [AW-1:0]   iss_rd,
   input  logic            flush,
   input  logic            clr_req,
   output logic            ready,
   input  logic [AW-1:0]   dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   localparam logic [0:0] SWEEP = 1'b0;
   localparam logic [0:0] READY = 1'b1;

   logic [0:0]      state, state_nxt;
   logic [AW-1:0]   ptr, ptr_nxt;
   logic            ready_nxt;
   logic            rdy_st;
   logic            w_ok, l_ok;
   logic [XLEN-1:0] regs [0:NREG-1];

   // Nonzero architectural register address
   function automatic logic in_rng(input logic [AW-1:0] a);
      return (a != '0) && (32'(a) < NREG);
   endfunction

   assign rdy_st = (state == READY);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SWEEP;
         ptr   <= AW'(1);
         ready <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         ready <= ready_nxt;
      end
   end

   // Next-state: sweep walks 1..NREG-1, clr_req restarts it
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         SWEEP: begin
            ptr_nxt = ptr + AW'(1);
            if (ptr == AW'(NREG - 1)) begin
               state_nxt = READY;
               ptr_nxt   = AW'(1);
            end
         end
         default: begin
            if (clr_req) begin
               state_nxt = SWEEP;
               ptr_nxt   = AW'(1);
            end
         end
      endcase
      ready_nxt = (state_nxt == READY);
   end

   // Write qualification; W takes the address when both ports collide
   assign w_ok = rdy_st && !clr_req && w_we && in_rng(w_addr);
   assign l_ok = rdy_st && !clr_req && l_we && in_rng(l_addr) &&
                 !(w_ok && (w_addr == l_addr));

   // Storage has no reset; the sweep zero-fills it
   always_ff @(posedge clk) begin
      if (!rdy_st) begin
         regs[ptr] <= '0;
      end else begin
         if (w_ok) regs[w_addr] <= w_data;
         if (l_ok) regs[l_addr] <= l_data;
      end
   end

   // Read port A with W-then-L bypass
   always_comb begin
      rd_a = '0;
      if (rdy_st && in_rng(ra_a)) begin
         if (w_we && (w_addr == ra_a))      rd_a = w_data;
         else if (l_we && (l_addr == ra_a)) rd_a = l_data;
         else                               rd_a = regs[ra_a];
      end
   end

   // Read port B with W-then-L bypass
   always_comb begin
      rd_b = '0;
      if (rdy_st && in_rng(ra_b)) begin
         if (w_we && (w_addr == ra_b))      rd_b = w_data;
         else if (l_we && (l_addr == ra_b)) rd_b = l_data;
         else                               rd_b = regs[ra_b];
      end
   end

   assign dbg_data = in_rng(dbg_addr) ? regs[dbg_addr] : '0;

`ifdef REGS_SB_SCOREBOARD_EN
   logic [NREG-1:0] busy, busy_nxt;

   // Busy update: flush/sweep clear all, issue beats a same-cycle return
   always_comb begin
      busy_nxt = busy;
      if (!rdy_st || clr_req || flush) begin
         busy_nxt = '0;
      end else begin
         for (int unsigned r = 1; r < NREG; r++) begin
            if (iss_ld && (iss_rd == AW'(r)))      busy_nxt[r] = 1'b1;
            else if (l_we && (l_addr == AW'(r)))   busy_nxt[r] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   // A same-cycle load return to the read address resolves via bypass
   assign hz_a = rdy_st && in_rng(ra_a) && busy[ra_a] &&
                 !(l_we && (l_addr == ra_a));
   assign hz_b = rdy_st && in_rng(ra_b) && busy[ra_b] &&
                 !(l_we && (l_addr == ra_b));
`else
   logic unused_sb;
   assign unused_sb = ^{iss_ld, iss_rd, flush};
   assign hz_a = 1'b0;
   assign hz_b = 1'b0;
`endif

endmodule
